// File: rtl/gelato_inst_buffer_pkg.sv
// Shared types and constants for the per-warp instruction buffer.
//   inst_t      : decoded instruction; warp_num selects the target FIFO
//   warp_num_t  : warp index
//   ib_ptr_t    : FIFO pointer, log2(depth)+1 bits (the extra MSB separates full from empty)
//   IB_*        : default sizing shared by the buffer and its users
package gelato_inst_buffer_pkg;

    localparam int IB_NUM_WARPS = 8;
    localparam int IB_WARP_W    = $clog2(IB_NUM_WARPS);
    localparam int IB_DEPTH     = 4;
    localparam int IB_AFULL_TH  = 1;
    localparam int IB_PTR_W     = $clog2(IB_DEPTH) + 1;

    typedef logic [IB_WARP_W-1:0] warp_num_t;
    typedef logic [IB_PTR_W-1:0]  ib_ptr_t;

    typedef struct packed {
        logic [31:0] pc;
        warp_num_t   warp_num;
        logic [31:0] opcode;
    } inst_t;

endpackage

// File: rtl/gelato_warp_fifo.sv
// Single-warp circular FIFO of inst_t.
//   clk, rst       : clock, synchronous active-high reset (pointers only)
//   enq, enq_data  : write one entry (ignored when full)
//   deq            : pop the head (ignored when empty)
//   flush          : empty the FIFO; wins over a same-cycle enq/deq
//   head           : combinational peek of the oldest entry
//   empty/full/afull : status derived from the registered pointers
module gelato_warp_fifo
    import gelato_inst_buffer_pkg::*;
#(
    parameter int DEPTH    = IB_DEPTH,
    parameter int AFULL_TH = IB_AFULL_TH
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  enq,
    input  inst_t enq_data,
    input  logic  deq,
    input  logic  flush,
    output inst_t head,
    output logic  empty,
    output logic  full,
    output logic  afull
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] rd_reg;
    logic [PTR_W-1:0] wr_reg;
    logic [PTR_W-1:0] count;
    logic [PTR_W:0]   free_cnt;
    logic             enq_fire;
    logic             deq_fire;

    // Storage is deliberately not reset; validity comes from the pointers.
    inst_t mem [DEPTH];

    assign empty = (rd_reg == wr_reg);
    assign full  = (rd_reg[PTR_W-1] != wr_reg[PTR_W-1]) &&
                   (rd_reg[IDX_W-1:0] == wr_reg[IDX_W-1:0]);
    // Pointers wrap modulo 2*DEPTH, so plain subtraction yields the occupancy.
    assign count    = wr_reg - rd_reg;
    assign free_cnt = (PTR_W+1)'(DEPTH) - {1'b0, count};
    assign afull    = (free_cnt <= (PTR_W+1)'(AFULL_TH));

    assign enq_fire = enq && !full && !flush;
    assign deq_fire = deq && !empty && !flush;

    assign head = mem[rd_reg[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_reg <= '0;
            wr_reg <= '0;
        end else if (flush) begin
            rd_reg <= '0;
            wr_reg <= '0;
        end else begin
            if (enq_fire) wr_reg <= wr_reg + 1'b1;
            if (deq_fire) rd_reg <= rd_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && enq_fire) begin
            mem[wr_reg[IDX_W-1:0]] <= enq_data;
        end
    end

endmodule

// File: rtl/gelato_inst_buffer.sv
// Per-warp instruction buffer between decoder and warp scheduler.
//   clk, rst        : clock, synchronous active-high reset
//   enq_valid/enq_inst/enq_ready : decoder push; target warp = enq_inst.warp_num
//   deq_req/deq_warp/deq_inst    : scheduler pop and combinational head peek
//   nonempty_mask/full_mask/afull_mask : per-warp status from registered pointers
//   flush_valid/flush_warp       : single-cycle clear of one warp's FIFO
module gelato_inst_buffer
    import gelato_inst_buffer_pkg::*;
#(
    parameter int NUM_WARPS = IB_NUM_WARPS,
    parameter int DEPTH     = IB_DEPTH,
    parameter int AFULL_TH  = IB_AFULL_TH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enq_valid,
    input  inst_t                enq_inst,
    output logic                 enq_ready,
    input  logic                 deq_req,
    input  warp_num_t            deq_warp,
    output inst_t                deq_inst,
    output logic [NUM_WARPS-1:0] nonempty_mask,
    output logic [NUM_WARPS-1:0] full_mask,
    output logic [NUM_WARPS-1:0] afull_mask,
    input  logic                 flush_valid,
    input  warp_num_t            flush_warp
);

    warp_num_t            enq_warp;
    logic [NUM_WARPS-1:0] enq_sel;
    logic [NUM_WARPS-1:0] deq_sel;
    logic [NUM_WARPS-1:0] flush_sel;
    logic [NUM_WARPS-1:0] empty_w;
    inst_t                head_w [NUM_WARPS];

    assign enq_warp = enq_inst.warp_num;

    // A flush of the target warp blocks the push so the decoder retries it
    // after the redirect; a same-cycle pop is not considered.
    assign enq_ready = !full_mask[enq_warp] && !flush_sel[enq_warp];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            assign flush_sel[gi] = flush_valid && (flush_warp == warp_num_t'(gi));
            assign enq_sel[gi]   = enq_valid && enq_ready && (enq_warp == warp_num_t'(gi));
            assign deq_sel[gi]   = deq_req && (deq_warp == warp_num_t'(gi));

            gelato_warp_fifo #(
                .DEPTH    (DEPTH),
                .AFULL_TH (AFULL_TH)
            ) u_fifo (
                .clk      (clk),
                .rst      (rst),
                .enq      (enq_sel[gi]),
                .enq_data (enq_inst),
                .deq      (deq_sel[gi]),
                .flush    (flush_sel[gi]),
                .head     (head_w[gi]),
                .empty    (empty_w[gi]),
                .full     (full_mask[gi]),
                .afull    (afull_mask[gi])
            );

            assign nonempty_mask[gi] = !empty_w[gi];
        end
    endgenerate

    // Empty FIFOs present zero so stale storage never leaks to the scheduler.
    always_comb begin
        deq_inst = '0;
        if (nonempty_mask[deq_warp]) begin
            deq_inst = head_w[deq_warp];
        end
    end

endmodule

// File: tb/tb_gelato_inst_buffer.sv
module tb_gelato_inst_buffer;
    import gelato_inst_buffer_pkg::*;

    localparam int NW = IB_NUM_WARPS;
    localparam int D  = IB_DEPTH;
    localparam int TH = IB_AFULL_TH;

    logic          clk = 1'b0;
    logic          rst;
    logic          enq_valid;
    inst_t         enq_inst;
    logic          enq_ready;
    logic          deq_req;
    warp_num_t     deq_warp;
    inst_t         deq_inst;
    logic [NW-1:0] nonempty_mask;
    logic [NW-1:0] full_mask;
    logic [NW-1:0] afull_mask;
    logic          flush_valid;
    warp_num_t     flush_warp;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: one plain queue of instructions per warp.
    inst_t ref_q [NW][$];

    gelato_inst_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .enq_valid     (enq_valid),
        .enq_inst      (enq_inst),
        .enq_ready     (enq_ready),
        .deq_req       (deq_req),
        .deq_warp      (deq_warp),
        .deq_inst      (deq_inst),
        .nonempty_mask (nonempty_mask),
        .full_mask     (full_mask),
        .afull_mask    (afull_mask),
        .flush_valid   (flush_valid),
        .flush_warp    (flush_warp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic inst_t mk(input warp_num_t w, input logic [31:0] pc);
        inst_t m;
        m.pc       = pc;
        m.warp_num = w;
        m.opcode   = $urandom;
        return m;
    endfunction

    task automatic setin(input logic ev, input inst_t ei, input logic dr, input warp_num_t dw,
                         input logic fv, input warp_num_t fw);
        enq_valid   = ev;
        enq_inst    = ei;
        deq_req     = dr;
        deq_warp    = dw;
        flush_valid = fv;
        flush_warp  = fw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model update: the spec's rules applied to queues at each clock edge.
    always @(posedge clk) begin
        if (chk_en || rst) begin
            if (rst) begin
                for (int w = 0; w < NW; w++) ref_q[w].delete();
            end else begin
                int ew;
                bit e_fire;
                bit d_fire;
                ew     = int'(enq_inst.warp_num);
                e_fire = enq_valid && (ref_q[ew].size() < D) &&
                         !(flush_valid && flush_warp == enq_inst.warp_num);
                d_fire = deq_req && (ref_q[deq_warp].size() > 0) &&
                         !(flush_valid && flush_warp == deq_warp);
                if (d_fire) void'(ref_q[deq_warp].pop_front());
                if (e_fire) ref_q[ew].push_back(enq_inst);
                if (flush_valid) ref_q[flush_warp].delete();
            end
        end
    end

    // Monitor: compares all DUT outputs against the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [NW-1:0] e_ne;
            logic [NW-1:0] e_fu;
            logic [NW-1:0] e_af;
            inst_t         e_head;
            logic          e_rdy;
            for (int w = 0; w < NW; w++) begin
                e_ne[w] = ref_q[w].size() > 0;
                e_fu[w] = ref_q[w].size() == D;
                e_af[w] = (D - ref_q[w].size()) <= TH;
            end
            e_rdy  = (ref_q[enq_inst.warp_num].size() < D) &&
                     !(flush_valid && flush_warp == enq_inst.warp_num);
            e_head = (ref_q[deq_warp].size() > 0) ? ref_q[deq_warp][0] : '0;
            chk("nonempty_mask", 128'(nonempty_mask), 128'(e_ne));
            chk("full_mask", 128'(full_mask), 128'(e_fu));
            chk("afull_mask", 128'(afull_mask), 128'(e_af));
            chk("enq_ready", 128'(enq_ready), 128'(e_rdy));
            chk("deq_inst", 128'(deq_inst), 128'(e_head));
            if (!rst && deq_req && e_ne[deq_warp] && !(flush_valid && flush_warp == deq_warp)) begin
                chk("pop_data", 128'(deq_inst), 128'(ref_q[deq_warp][0]));
            end
        end
    end

    initial begin
        inst_t z;
        z = '0;
        rst = 1'b1;
        setin(0, z, 0, 0, 0, 0);
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_nonempty", 128'(nonempty_mask), 128'(0));
        chk("rst_enq_ready", 128'(enq_ready), 128'(1));
        chk("rst_deq_inst", 128'(deq_inst), 128'(0));

        // Single enqueue to warp 3, visible one cycle later.
        setin(1, mk(3, 32'h100), 0, 3, 0, 0);
        #1 chk("t1_enq_ready", 128'(enq_ready), 128'(1));
        chk("t1_not_yet", 128'(nonempty_mask), 128'(0));
        tick();
        setin(0, z, 0, 3, 0, 0);
        #1 chk("t1_nonempty", 128'(nonempty_mask), 128'(8'h08));
        chk("t1_pc", 128'(deq_inst.pc), 128'(32'h100));
        setin(0, z, 1, 3, 0, 0);
        tick();

        // Fill warp 0, check almost-full/full thresholds and order.
        for (int i = 0; i < 4; i++) begin
            setin(1, mk(0, 32'(i * 4)), 0, 0, 0, 0);
            tick();
            chk("t2_afull", 128'(afull_mask[0]), 128'(i >= 2));
        end
        chk("t2_full", 128'(full_mask[0]), 128'(1));
        setin(1, mk(0, 32'h10), 0, 0, 0, 0);
        #1 chk("t2_5th_ready", 128'(enq_ready), 128'(0));
        tick();
        for (int i = 0; i < 4; i++) begin
            setin(0, z, 1, 0, 0, 0);
            #1 chk("t2_pop_pc", 128'(deq_inst.pc), 128'(32'(i * 4)));
            tick();
        end
        chk("t2_empty", 128'(nonempty_mask[0]), 128'(0));

        // Warp 1 full: same-cycle enq+deq only pops.
        for (int i = 0; i < 4; i++) begin
            setin(1, mk(1, 32'h200 + 32'(i)), 0, 0, 0, 0);
            tick();
        end
        setin(1, mk(1, 32'hBAD1), 1, 1, 0, 0);
        #1 chk("t3_enq_ready", 128'(enq_ready), 128'(0));
        tick();
        setin(0, z, 0, 1, 0, 0);
        #1 chk("t3_not_full", 128'(full_mask[1]), 128'(0));
        chk("t3_head", 128'(deq_inst.pc), 128'(32'h201));

        // Flush warp 2 with same-cycle enq and deq; warp 5 untouched.
        setin(1, mk(5, 32'h500), 0, 0, 0, 0);
        tick();
        setin(1, mk(2, 32'h300), 0, 0, 0, 0);
        tick();
        setin(1, mk(2, 32'h304), 0, 0, 0, 0);
        tick();
        setin(1, mk(2, 32'hBAD2), 1, 2, 1, 2);
        #1 chk("t4_enq_ready", 128'(enq_ready), 128'(0));
        tick();
        setin(0, z, 0, 2, 0, 0);
        #1 chk("t4_flushed", 128'(nonempty_mask[2]), 128'(0));
        chk("t4_deq_zero", 128'(deq_inst), 128'(0));
        setin(0, z, 0, 5, 0, 0);
        #1 chk("t4_w5_pc", 128'(deq_inst.pc), 128'(32'h500));
        setin(1, mk(2, 32'h308), 0, 2, 0, 0);
        tick();
        setin(0, z, 0, 2, 0, 0);
        #1 chk("t4_after_flush_pc", 128'(deq_inst.pc), 128'(32'h308));

        // Warp 7: 10 entries through, wrapping pointers past 2*DEPTH.
        for (int r = 0; r < 3; r++) begin
            int n;
            n = (r == 2) ? 2 : 4;
            for (int i = 0; i < n; i++) begin
                setin(1, mk(7, 32'h700 + 32'((r * 4 + i) * 4)), 0, 0, 0, 0);
                tick();
            end
            chk("t5_full", 128'(full_mask[7]), 128'(n == 4));
            for (int i = 0; i < n; i++) begin
                setin(0, z, 1, 7, 0, 0);
                #1 chk("t5_pc", 128'(deq_inst.pc), 128'(32'h700 + 32'((r * 4 + i) * 4)));
                tick();
            end
            chk("t5_empty", 128'(nonempty_mask[7]), 128'(0));
        end

        // Reset mid-operation with several warps populated and an enq in flight.
        setin(1, mk(6, 32'h600), 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        setin(1, mk(4, 32'h400), 0, 4, 0, 0);
        tick();
        rst = 1'b0;
        setin(0, z, 0, 4, 0, 0);
        #1 chk("t6_nonempty", 128'(nonempty_mask), 128'(0));
        chk("t6_full", 128'(full_mask), 128'(0));
        chk("t6_afull", 128'(afull_mask), 128'(0));
        chk("t6_deq_inst", 128'(deq_inst), 128'(0));
        chk("t6_enq_ready", 128'(enq_ready), 128'(1));

        // Random traffic, checked cycle by cycle by the monitor.
        for (int c = 0; c < 3000; c++) begin
            warp_num_t ew;
            ew = warp_num_t'($urandom_range(0, NW - 1));
            rst = ($urandom_range(0, 299) == 0);
            setin($urandom_range(0, 3) != 0, mk(ew, $urandom),
                  $urandom_range(0, 2) != 0, warp_num_t'($urandom_range(0, NW - 1)),
                  $urandom_range(0, 15) == 0, warp_num_t'($urandom_range(0, NW - 1)));
            tick();
        end
        rst = 1'b0;
        setin(0, z, 0, 0, 0, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gelato_inst_buffer.md
Name: gelato_inst_buffer

Overview:
Per-warp instruction buffer between the decoder and the warp scheduler. Holds up to DEPTH decoded inst_t entries for each of NUM_WARPS warps, in independent circular FIFOs. Accepts one enqueue and one dequeue per cycle. Supports a single-cycle per-warp flush for branch and reconvergence redirects. Exports per-warp ready/full/almost-full masks to the scheduler and the fetch throttle.

Parameters:
NUM_WARPS, 8, number of warps and independent FIFOs; power of 2, matches WARP_NUM width
DEPTH, 4, entries per warp FIFO; power of 2, >= 2
AFULL_TH, 1, almost_full asserted when free entries <= AFULL_TH

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enq_valid  in  1  decoder presents an instruction
enq_inst  in  inst_t  instruction; target FIFO selected by enq_inst.warp_num
enq_ready  out  1  target FIFO can accept this cycle
deq_req  in  1  scheduler pops the head of deq_warp
deq_warp  in  warp_num_t  warp to pop/peek
deq_inst  out  inst_t  head entry of deq_warp (combinational peek)
nonempty_mask  out  NUM_WARPS  bit w = FIFO w holds >= 1 entry
full_mask  out  NUM_WARPS  bit w = FIFO w holds DEPTH entries
afull_mask  out  NUM_WARPS  bit w = free entries of FIFO w <= AFULL_TH
flush_valid  in  1  clear one warp's FIFO
flush_warp  in  warp_num_t  warp to flush

Behaviour:
- Reset: all read/write pointers are 0; nonempty_mask=0, full_mask=0, afull_mask=0 (0 when AFULL_TH < DEPTH); enq_ready=1; deq_inst=0. Storage is not reset.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH:
  - empty = (rd==wr)
  - full = (MSBs differ, low bits equal)
  - count = wr - rd, modulo arithmetic
- Enqueue:
  - Fires when enq_valid & enq_ready.
  - Writes slot wr[low]; wr increments at the clock edge.
  - The entry is visible at deq_inst and in nonempty_mask the next cycle. Latency 1; no same-cycle bypass.
- enq_ready = !full[enq_inst.warp_num] & !(flush_valid & flush_warp==enq_inst.warp_num).
  - It does not consider a same-cycle dequeue, so a full FIFO refuses enqueue even while it is popped.
- Dequeue:
  - Fires when deq_req & nonempty[deq_warp]; rd increments.
  - deq_inst = storage[deq_warp][rd[low]] when nonempty, else all-zero.
  - deq_req to an empty warp is ignored and causes no pointer change.
- Simultaneous enqueue and dequeue:
  - Same warp, not full: both fire; count unchanged.
  - Different warps: both fire independently.
- Flush:
  - Sets rd=wr=0 for flush_warp at the clock edge.
  - Overrides any same-cycle enqueue to that warp (enq_ready forced 0, no write) and any same-cycle dequeue of that warp (no pop).
  - The scheduler must treat the dequeue as not performed.
  - Other warps are unaffected.
- Masks are registered-state functions, combinational from the pointers; they change only at clock edges.
- Reset asserted mid-operation: all FIFOs empty on the next cycle, and in-flight enqueues are dropped.
- Instruction order within a warp is strictly FIFO. No ordering is defined between warps.

Decomposition:
- Shared package gelato_types gains:
  - typedef ib_ptr_t (log2(DEPTH)+1 bits)
  - constants IB_DEPTH and IB_AFULL_TH
  - macros INST_BUFFER_DEPTH and INST_BUFFER_AFULL_TH in gelato_macros.svh
- inst_buffer_entry_t is reused only if a valid bit per slot is kept; valid is implied by pointers, so it is not required.
- Sub-module gelato_warp_fifo (single-warp FIFO):
  - Ports: enq, deq, flush, head, empty, full, afull.
  - Generated NUM_WARPS times.
- The top level does the warp_num decode and output muxing.

Test Plan:
- Reset, then enq warp 3 pc=0x100 -> enq_ready=1; next cycle nonempty_mask=0x08, deq_inst.pc=0x100 with deq_warp=3.
- Fill warp 0 with pcs 0x0,0x4,0x8,0xC -> full_mask[0]=1, afull_mask[0] set after the 3rd enqueue, 5th enqueue gets enq_ready=0; pops return 0x0,0x4,0x8,0xC in order.
- Warp 1 full, enq and deq to warp 1 in the same cycle -> enq_ready=0, only the pop occurs; count goes 4->3.
- Warp 2 holds 2 entries; flush warp 2 with a same-cycle enq and deq to warp 2 -> next cycle nonempty_mask[2]=0; the enqueued inst never appears; warp 5 contents unaffected.
- Push/pop 10 entries through warp 7 (pointer wrap past 2*DEPTH) -> data order preserved; empty/full correct at each wrap.
- Assert rst with 3 warps non-empty -> next cycle all masks 0, deq_inst=0, enq_ready=1.
